// File: rtl/sevenseg_pkg.sv
// Shared constants, state encoding and segment table for the six-digit 7-segment scanner.
// Leading-zero blanking helper is used only when SEVENSEG_LZ_BLANK_EN is defined.
package sevenseg_pkg;

   localparam int NUM_DIGITS = 6;
   localparam logic [6:0] SEG_OFF = 7'h7f;
   localparam logic [5:0] SEL_OFF = 6'h3f;

   typedef enum logic {
      StGap,
      StShow
   } state_e;

   // Active-low g..a patterns, index 15 first.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0e, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // Digit k (k>=1) is blanked while it and every higher digit is zero or disabled.
   function automatic logic [NUM_DIGITS-1:0] lz_blank(
      input logic [NUM_DIGITS-1:0][3:0] dig,
      input logic [NUM_DIGITS-1:0]      en
   );
      logic                  zero_run;
      logic [NUM_DIGITS-1:0] res;
      res      = en;
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run = zero_run & ((dig[k] == 4'h0) | ~en[k]);
         if (zero_run) res[k] = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex digit to active-low 7-segment pattern (bit0 = segment a).
module hex7seg_decode (
   input  logic [3:0] value,
   output logic [6:0] pattern
);
   import sevenseg_pkg::*;

   assign pattern = SEG_TABLE[value];

endmodule

// File: rtl/sevenseg_scanner.sv
// Double-buffered, time-multiplexed six-digit 7-segment driver with per-slot blanking gap.
// Optional build macro: SEVENSEG_LZ_BLANK_EN (blank leading zeros when the shadow is loaded).
module sevenseg_scanner #(
   parameter int unsigned DIGIT_CYCLES = 1000,
   parameter int unsigned GAP_CYCLES   = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [23:0] digits,
   input  logic [5:0]  dp,
   input  logic [5:0]  en,
   output logic [7:0]  seg,
   output logic [5:0]  sel_n,
   output logic        frame_done
);
   import sevenseg_pkg::*;

   localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   state_e           state_q, state_d;

   logic [NUM_DIGITS-1:0][3:0] pend_dig_q, shadow_dig_q, shadow_dig_d;
   logic [NUM_DIGITS-1:0]      pend_dp_q, pend_en_q, pend_q;
   logic [NUM_DIGITS-1:0]      shadow_dp_q, shadow_dp_d, shadow_en_q, shadow_en_d;
   logic                       pend_flag_q;

   logic       slot_last, frame_last;
   logic [3:0] cur_digit;
   logic [6:0] cur_pattern;
   logic [7:0] seg_d;
   logic [5:0] sel_n_d;

   assign pend_q = pend_en_q;

   always_comb begin
      slot_last  = (cnt_q == CNT_LAST);
      frame_last = slot_last && (idx_q == IDX_LAST);
      cnt_d      = slot_last ? '0 : cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      if (slot_last) idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;

      state_d = state_q;
      case (state_q)
         StGap:   if (cnt_q == GAP_LAST) state_d = StShow;
         StShow:  if (slot_last) state_d = StGap;
         default: state_d = StGap;
      endcase

      shadow_dig_d = shadow_dig_q;
      shadow_dp_d  = shadow_dp_q;
      shadow_en_d  = shadow_en_q;
      if (frame_last && pend_flag_q) begin
         shadow_dig_d = pend_dig_q;
         shadow_dp_d  = pend_dp_q;
`ifdef SEVENSEG_LZ_BLANK_EN
         shadow_en_d  = lz_blank(pend_dig_q, pend_q);
`else
         shadow_en_d  = pend_q;
`endif
      end
   end

   // Outputs are registered from next-state values so select and data switch together.
   assign cur_digit = shadow_dig_d[idx_d];

   hex7seg_decode u_decode (
      .value   (cur_digit),
      .pattern (cur_pattern)
   );

   always_comb begin
      sel_n_d = SEL_OFF;
      seg_d   = {1'b1, SEG_OFF};
      if (state_d == StShow && shadow_en_d[idx_d]) begin
         sel_n_d[idx_d] = 1'b0;
         seg_d          = {~shadow_dp_d[idx_d], cur_pattern};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= 3'd0;
         state_q      <= StGap;
         pend_dig_q   <= '0;
         pend_dp_q    <= '0;
         pend_en_q    <= '0;
         pend_flag_q  <= 1'b0;
         shadow_dig_q <= '0;
         shadow_dp_q  <= '0;
         shadow_en_q  <= '0;
         seg          <= {1'b1, SEG_OFF};
         sel_n        <= SEL_OFF;
         frame_done   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         state_q      <= state_d;
         shadow_dig_q <= shadow_dig_d;
         shadow_dp_q  <= shadow_dp_d;
         shadow_en_q  <= shadow_en_d;
         seg          <= seg_d;
         sel_n        <= sel_n_d;
         frame_done   <= frame_last;
         // A load on the boundary wins: the old pending moves to shadow, the new one waits.
         if (load) begin
            pend_dig_q  <= digits;
            pend_dp_q   <= dp;
            pend_en_q   <= en;
            pend_flag_q <= 1'b1;
         end else if (frame_last) begin
            pend_flag_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Self-checking bench: directed scenarios plus random loads against a cycle-count model.
// Honors SEVENSEG_LZ_BLANK_EN when defined at build time.
module tb_sevenseg_scanner;

   localparam int DC    = 8;
   localparam int GC    = 2;
   localparam int FRAME = 6 * DC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [23:0] digits = '0;
   logic [5:0]  dp = '0;
   logic [5:0]  en = '0;
   logic [7:0]  seg;
   logic [5:0]  sel_n;
   logic        frame_done;

   int total = 0;
   int bad   = 0;

   // Model state: n = clocks since reset release, plus pending/shown buffers.
   int          n = 0;
   logic [23:0] p_dig = '0, s_dig = '0;
   logic [5:0]  p_dp = '0, p_en = '0, s_dp = '0, s_en = '0;
   bit          p_flag = 0;
   logic        exp_fd = 1'b0;
   logic [6:0]  hex_lut [16];

   sevenseg_scanner #(
      .DIGIT_CYCLES (DC),
      .GAP_CYCLES   (GC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .digits     (digits),
      .dp         (dp),
      .en         (en),
      .seg        (seg),
      .sel_n      (sel_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Highest enabled non-zero digit sets how far down blanking reaches.
   function automatic logic [5:0] shown_en(input logic [23:0] d, input logic [5:0] e);
`ifdef SEVENSEG_LZ_BLANK_EN
      int top = 0;
      for (int k = 0; k < 6; k++)
         if (e[k] && ((d >> (4 * k)) & 24'hf) != 0) top = k;
      return e & 6'((1 << (top + 1)) - 1);
`else
      return e;
`endif
   endfunction

   task automatic model_edge();
      bit boundary;
      if (!rst_n) begin
         n = 0; s_en = '0; p_flag = 0; exp_fd = 1'b0;
      end else begin
         boundary = (n % FRAME) == FRAME - 1;
         exp_fd   = boundary;
         if (boundary && p_flag) begin
            s_dig = p_dig; s_dp = p_dp; s_en = shown_en(p_dig, p_en);
         end
         if (load) begin
            p_dig = digits; p_dp = dp; p_en = en; p_flag = 1;
         end else if (boundary) begin
            p_flag = 0;
         end
         n++;
      end
   endtask

   task automatic check_outputs();
      int         slot, pos;
      logic [7:0] e_seg;
      logic [5:0] e_sel;
      slot  = (n / DC) % 6;
      pos   = n % DC;
      e_seg = 8'hff;
      e_sel = 6'h3f;
      if (pos >= GC && s_en[slot]) begin
         e_sel = ~(6'd1 << slot);
         e_seg = {~s_dp[slot], hex_lut[(s_dig >> (4 * slot)) & 24'hf]};
      end
      total += 3;
      assert (sel_n === e_sel) else begin
         bad++; $error("FAIL sel_n n=%0d got=%h exp=%h", n, sel_n, e_sel);
      end
      assert (seg === e_seg) else begin
         bad++; $error("FAIL seg n=%0d got=%h exp=%h", n, seg, e_seg);
      end
      assert (frame_done === exp_fd) else begin
         bad++; $error("FAIL frame_done n=%0d got=%b exp=%b", n, frame_done, exp_fd);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) tick();
   endtask

   // Advance until the next edge is taken at frame position pos (bounded to one frame).
   task automatic run_to(input int pos);
      for (int i = 0; i < FRAME && (n % FRAME) != pos; i++) tick();
   endtask

   task automatic do_load(input logic [23:0] d, input logic [5:0] p, input logic [5:0] e);
      digits = d; dp = p; en = e; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      hex_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

      // Reset, then dark until a load crosses a boundary.
      rst_n = 1'b0;
      run(3);
      rst_n = 1'b1;
      run(FRAME + 5);

      // Basic pattern, two full frames after the swap.
      do_load(24'h543210, 6'h00, 6'h3f);
      run(3 * FRAME);

      // Mid-frame load while idx==2 must not disturb slots 3..5 of this frame.
      run_to(2 * DC + 3);
      do_load(24'hAAAAAA, 6'h00, 6'h3f);
      run(2 * FRAME);

      // Partially disabled digits keep their time slots.
      do_load(24'h543210, 6'h00, 6'b000101);
      run(2 * FRAME + 4);

      // Decimal point on digit 0, then off.
      do_load(24'h000008, 6'h01, 6'h3f);
      run(2 * FRAME);
      do_load(24'h000008, 6'h00, 6'h3f);
      run(2 * FRAME);

      // Leading zeros (blanked only when the macro is defined).
      do_load(24'h000120, 6'h00, 6'h3f);
      run(2 * FRAME);
      do_load(24'h000000, 6'h2a, 6'h3f);
      run(2 * FRAME);

      // Load exactly on the boundary cycle: shown from the frame after next.
      run_to(FRAME - 1);
      do_load(24'h13579b, 6'h15, 6'h3f);
      run(2 * FRAME + 3);

      // Reset mid-frame with a load pending drops everything.
      do_load(24'hfedcba, 6'h3f, 6'h3f);
      run_to(3 * DC + 4);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      run(2 * FRAME);

      // Random loads at random points, including back-to-back overwrites.
      for (int i = 0; i < 24; i++) begin
         run($urandom_range(0, 60));
         do_load($urandom, 6'($urandom), 6'($urandom));
      end
      run(2 * FRAME);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
